// File: rtl/sata_link_fifo_pkg.sv
// sata_link_fifo_pkg: shared mode names and write-side state encoding for the link frame FIFO.
package sata_link_fifo_pkg;
    localparam string MODE_CUT = "CUT";
    localparam string MODE_SAF = "SAF";
    typedef enum logic [0:0] {W_FRAME, W_DISCARD} wstate_t;
endpackage

// File: rtl/sata_link_fifo_ram.sv
// sata_link_fifo_ram: simple dual-port RAM, one write port and one registered read port.
module sata_link_fifo_ram #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 128,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/sata_link_frame_fifo.sv
// sata_link_frame_fifo: single-clock frame FIFO with cut-through or store-and-forward commit,
// show-ahead read side and oversize/error frame discard.
module sata_link_frame_fifo
    import sata_link_fifo_pkg::*;
#(
    parameter int    DWIDTH   = 32,
    parameter int    DEPTH    = 128,
    parameter int    AE_LEVEL = 2,
    parameter int    AF_LEVEL = DEPTH / 2,
    parameter string MODE     = "CUT",
    parameter int    DROP_ERR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     wr_eop,
    input  logic                     wr_err,
    input  logic                     wr_req,
    output logic                     wr_full,
    output logic                     wr_almostfull,
    output logic [$clog2(DEPTH):0]   wr_used,
    output logic                     wr_ovf,
    output logic                     wr_drop,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     rd_eop,
    output logic                     rd_err,
    input  logic                     rd_req,
    output logic                     rd_empty,
    output logic                     rd_almostempty,
    output logic [$clog2(DEPTH):0]   rd_frames
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam bit CUT = (MODE == MODE_CUT);
    localparam bit SAF = (MODE == MODE_SAF);
    localparam bit DROP = SAF && (DROP_ERR != 0);

    logic [PW-1:0] rp, wp, cwp, rp_nx, wp_nx, cwp_nx, readable;
    logic [DWIDTH+1:0] word, ram_q, byp_q;
    logic wr_acc, rd_acc, ovf_drop, err_drop, commit, byp;
    wstate_t state;

    assign wr_used = wp - rp;
    assign readable = cwp - rp;
    assign wr_full = wr_used == PW'(DEPTH);
    assign wr_almostfull = wr_used >= PW'(AF_LEVEL);
    assign rd_empty = readable == '0;
    assign rd_almostempty = readable < PW'(AE_LEVEL);
    assign wr_acc = wr_req && !wr_full && state == W_FRAME;
    assign rd_acc = rd_req && !rd_empty;
    // a frame that cannot fit even with nothing else resident is abandoned
    assign ovf_drop = SAF && state == W_FRAME && wr_req && wr_full && rd_frames == '0;
    assign err_drop = DROP && wr_acc && wr_eop && wr_err;
    assign commit = wr_acc && wr_eop && !err_drop;
    assign wp_nx = (ovf_drop || err_drop) ? cwp : wp + PW'(wr_acc);
    assign cwp_nx = CUT ? wp_nx : commit ? wp + 1'b1 : cwp;
    assign rp_nx = rp + PW'(rd_acc);
    assign word = {wr_err, wr_eop, wr_data};
    // RAM reads old data on a same-address write, so a word landing at the head is forwarded
    assign {rd_err, rd_eop, rd_data} = byp ? byp_q : ram_q;

    sata_link_fifo_ram #(.WIDTH(DWIDTH + 2), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wp[AW-1:0]),
        .wdata (word),
        .raddr (rp_nx[AW-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rp        <= '0;
            wp        <= '0;
            cwp       <= '0;
            state     <= W_FRAME;
            rd_frames <= '0;
            wr_ovf    <= 1'b0;
            wr_drop   <= 1'b0;
            byp       <= 1'b0;
        end else begin
            rp        <= rp_nx;
            wp        <= wp_nx;
            cwp       <= cwp_nx;
            rd_frames <= rd_frames + PW'(commit) - PW'(rd_acc && rd_eop);
            wr_ovf    <= wr_req && state == W_FRAME && !wr_acc && !ovf_drop;
            wr_drop   <= ovf_drop || err_drop;
            byp       <= wr_acc && wp[AW-1:0] == rp_nx[AW-1:0];
            state     <= ovf_drop ? W_DISCARD :
                         (state == W_DISCARD && wr_req && wr_eop) ? W_FRAME : state;
        end
    end

    always_ff @(posedge clk) byp_q <= word;
endmodule
